game_sequencer: RTL and testbench

Frame-level controller for the Flappy-style game. Sequences one update of the pipe renderer and one update of the bird renderer per scheduled frame, using the request/finish handshake the renderers expose (`updatepipe`/`pipefinish`, `updatebird`/`birdfinish`). It also owns the title/play/game-over state machine, the collision latch and the two-digit BCD score. It sits between the button inputs, the VGA scan counters and the sprite renderers.

---
 rtl/game_sequencer.sv | 161 ++++++++++++++++
 tb/tb_game_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Frame-level sequencer: title/play/over FSM, pipe-then-bird renderer handshake, hit latch, BCD score.
// Optional GAME_SEQ_GODMODE_EN: collisions are ignored and play never ends.
module game_sequencer #(
    parameter int FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       resetGame_n,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       start_btn,
    input  logic       flap_btn,
    input  logic       collide,
    input  logic       pipe_pass,
    input  logic       pipefinish,
    input  logic       birdfinish,
    output logic       updatepipe,
    output logic       updatebird,
    output logic       flap,
    output logic       resetPlay,
    output logic [1:0] game_state,
    output logic [7:0] score
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT_FRAME, S_PIPE_REQ, S_PIPE_REL,
        S_BIRD_REQ, S_BIRD_REL, S_CHECK, S_OVER
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

    state_t     state_q, state_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic [7:0] score_q, score_d;
    logic       hit_q, hit_d;
    logic       flap_pending_q, flap_pending_d;
    logic       start_btn_q, flap_btn_q;
    logic       updatepipe_q, updatepipe_d;
    logic       updatebird_q, updatebird_d;
    logic       flap_q, flap_d;
    logic       reset_play_q, reset_play_d;
    logic [1:0] game_state_q, game_state_d;

    logic eof, start_rise, flap_rise, playing, in_window, flap_clear;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return 8'h99;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        eof        = (x == 10'd639) && (y == 9'd479);
        start_rise = start_btn & ~start_btn_q;
        flap_rise  = flap_btn & ~flap_btn_q;
        playing    = (state_q != S_IDLE) && (state_q != S_OVER);
        in_window  = playing && (state_q != S_START);

        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        score_d    = score_q;
        hit_d      = hit_q;
        flap_clear = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: if (start_rise) state_d = S_START;
            S_START: begin
                state_d    = S_WAIT_FRAME;
                div_cnt_d  = 4'd0;
                score_d    = 8'h00;
                hit_d      = 1'b0;
                flap_clear = 1'b1;
            end
            S_WAIT_FRAME: begin
                if (eof) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = 4'd0;
                        state_d   = S_PIPE_REQ;
                    end else begin
                        div_cnt_d = div_cnt_q + 4'd1;
                    end
                end
            end
            S_PIPE_REQ: if (pipefinish) state_d = S_PIPE_REL;
            S_PIPE_REL: if (!pipefinish) state_d = S_BIRD_REQ;
            S_BIRD_REQ: begin
                if (birdfinish) begin
                    state_d    = S_BIRD_REL;
                    flap_clear = 1'b1;
                end
            end
            S_BIRD_REL: if (!birdfinish) state_d = S_CHECK;
            S_CHECK:    state_d = hit_q ? S_OVER : S_WAIT_FRAME;
            default:    state_d = S_IDLE;
        endcase

`ifndef GAME_SEQ_GODMODE_EN
        if (in_window && collide) hit_d = 1'b1;
`endif
        if (in_window && pipe_pass) score_d = bcd_inc(score_q);

        // A flap edge landing on the clearing cycle must not be lost.
        if (flap_rise && playing)
            flap_pending_d = 1'b1;
        else if (flap_clear)
            flap_pending_d = 1'b0;
        else
            flap_pending_d = flap_pending_q;

        updatepipe_d = (state_d == S_PIPE_REQ);
        updatebird_d = (state_d == S_BIRD_REQ);
        flap_d       = (state_d == S_BIRD_REQ) && flap_pending_d;
        reset_play_d = (state_d == S_START);
        if (state_d == S_IDLE)
            game_state_d = 2'd0;
        else if (state_d == S_OVER)
            game_state_d = 2'd2;
        else
            game_state_d = 2'd1;
    end

    always_ff @(posedge clk or negedge resetGame_n) begin
        if (!resetGame_n) begin
            state_q        <= S_IDLE;
            div_cnt_q      <= 4'd0;
            score_q        <= 8'h00;
            hit_q          <= 1'b0;
            flap_pending_q <= 1'b0;
            start_btn_q    <= 1'b0;
            flap_btn_q     <= 1'b0;
            updatepipe_q   <= 1'b0;
            updatebird_q   <= 1'b0;
            flap_q         <= 1'b0;
            reset_play_q   <= 1'b0;
            game_state_q   <= 2'd0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            score_q        <= score_d;
            hit_q          <= hit_d;
            flap_pending_q <= flap_pending_d;
            start_btn_q    <= start_btn;
            flap_btn_q     <= flap_btn;
            updatepipe_q   <= updatepipe_d;
            updatebird_q   <= updatebird_d;
            flap_q         <= flap_d;
            reset_play_q   <= reset_play_d;
            game_state_q   <= game_state_d;
        end
    end

    assign updatepipe = updatepipe_q;
    assign updatebird = updatebird_q;
    assign flap       = flap_q;
    assign resetPlay  = reset_play_q;
    assign game_state = game_state_q;
    assign score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer (FRAME_DIV = 3): stimulus queues expected output events,
// a monitor detects output events and pops/compares them.
module tb_game_sequencer;

    localparam int FD = 3;
    localparam int K_SNAP = 0, K_STATE = 1, K_RPLAY = 2, K_SCORE = 3, K_PIPE = 4, K_BIRD = 5;

    logic       clk = 1'b0;
    logic       resetGame_n = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       start_btn = 1'b0, flap_btn = 1'b0, collide = 1'b0, pipe_pass = 1'b0;
    logic       pipefinish = 1'b0, birdfinish = 1'b0;
    logic       updatepipe, updatebird, flap, resetPlay;
    logic [1:0] game_state;
    logic [7:0] score;

    typedef struct {int kind; int val;} ev_t;
    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    int pipe_hi = 0, pipe_lo = 0, bird_hi = 0, bird_lo = 0;
    int p_hi_cnt = 0, p_lo_cnt = 0, b_hi_cnt = 0, b_lo_cnt = 0;

    game_sequencer #(.FRAME_DIV(FD)) dut (
        .clk(clk), .resetGame_n(resetGame_n), .x(x), .y(y),
        .start_btn(start_btn), .flap_btn(flap_btn), .collide(collide), .pipe_pass(pipe_pass),
        .pipefinish(pipefinish), .birdfinish(birdfinish),
        .updatepipe(updatepipe), .updatebird(updatebird), .flap(flap), .resetPlay(resetPlay),
        .game_state(game_state), .score(score)
    );

    always #5 clk = ~clk;

    // Renderer models: finish rises pipe_hi cycles after the request, falls pipe_lo cycles after release.
    always @(posedge clk) begin
        #1;
        if (updatepipe) begin
            p_lo_cnt = 0;
            if (p_hi_cnt >= pipe_hi) pipefinish = 1'b1; else p_hi_cnt++;
        end else begin
            p_hi_cnt = 0;
            if (pipefinish) begin
                if (p_lo_cnt >= pipe_lo) pipefinish = 1'b0; else p_lo_cnt++;
            end
        end
        if (updatebird) begin
            b_lo_cnt = 0;
            if (b_hi_cnt >= bird_hi) birdfinish = 1'b1; else b_hi_cnt++;
        end else begin
            b_hi_cnt = 0;
            if (birdfinish) begin
                if (b_lo_cnt >= bird_lo) birdfinish = 1'b0; else b_lo_cnt++;
            end
        end
    end

    function automatic string kind_name(input int k);
        case (k)
            K_SNAP:  return "reset_snapshot";
            K_STATE: return "game_state";
            K_RPLAY: return "resetPlay_rise";
            K_SCORE: return "score";
            K_PIPE:  return "pipe_window";
            default: return "bird_window";
        endcase
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [3:0] t, u;
        t = v[7:4];
        u = v[3:0];
        if (v == 8'h99) return v;
        if (u == 4'd9) return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    task automatic push_exp(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input int kind, input int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_%s actual=%0h required=no event", kind_name(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                n_fail++;
                $display("[TB] FAIL %s actual=%s:%0h required=%s:%0h",
                         kind_name(e.kind), kind_name(kind), val, kind_name(e.kind), e.val);
            end
        end
    endtask

    // Monitor: turns output activity into events; request windows report on their falling edge.
    initial begin
        logic [1:0] prev_gs;
        logic [7:0] prev_score;
        logic       prev_rp, prev_up, prev_ub;
        logic       pw_bird, bw_pipe, bw_and, bw_or;
        int         rp_w;
        @(posedge resetGame_n);
        @(negedge clk);
        checkOutput(K_SNAP, {updatepipe, updatebird, flap, resetPlay, game_state, score});
        prev_gs = game_state; prev_score = score; prev_rp = resetPlay;
        prev_up = updatepipe; prev_ub = updatebird;
        pw_bird = 1'b0; bw_pipe = 1'b0; bw_and = 1'b1; bw_or = 1'b0; rp_w = 0;
        forever begin
            @(negedge clk);
            if (game_state != prev_gs) checkOutput(K_STATE, game_state);
            if (resetPlay && !prev_rp) checkOutput(K_RPLAY, 1);
            if (resetPlay) rp_w++;
            if (!resetPlay && prev_rp) begin
                n_checks++;
                if (rp_w != 1) begin
                    n_fail++;
                    $display("[TB] FAIL resetPlay_width actual=%0d required=1", rp_w);
                end
                rp_w = 0;
            end
            if (score != prev_score) checkOutput(K_SCORE, score);
            if (updatepipe) pw_bird |= updatebird;
            if (!updatepipe && prev_up) begin
                checkOutput(K_PIPE, pw_bird);
                pw_bird = 1'b0;
            end
            if (updatebird) begin
                bw_pipe |= updatepipe;
                bw_and  &= flap;
                bw_or   |= flap;
            end
            if (!updatebird && prev_ub) begin
                checkOutput(K_BIRD, {bw_pipe, bw_and, bw_or});
                bw_pipe = 1'b0; bw_and = 1'b1; bw_or = 1'b0;
            end
            prev_gs = game_state; prev_score = score; prev_rp = resetPlay;
            prev_up = updatepipe; prev_ub = updatebird;
        end
    end

    task automatic applyStimulus(input int n_eof, input int gap);
        for (int i = 0; i < n_eof; i++) begin
            @(negedge clk); x = 10'd639; y = 9'd479;
            @(negedge clk); x = 10'd0;   y = 9'd0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_pass();
        @(negedge clk) pipe_pass = 1'b1;
        @(negedge clk) pipe_pass = 1'b0;
    endtask

    task automatic wait_pipe_req(input string what);
        int n;
        n = 0;
        while (!updatepipe && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!updatepipe) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout actual=updatepipe 0 required=updatepipe 1", what);
        end
    endtask

    initial begin
        logic [7:0] s;
        // Reset, then title start.
        repeat (3) @(negedge clk);
        push_exp(K_SNAP, 0);
        resetGame_n = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(K_STATE, 1);
        push_exp(K_RPLAY, 1);
        press_start();

        // Slow handshake, FD eofs schedule one update.
        pipe_hi = 5; pipe_lo = 2; bird_hi = 5; bird_lo = 2;
        push_exp(K_PIPE, 0);
        push_exp(K_BIRD, 0);
        applyStimulus(FD, 4);
        repeat (50) @(negedge clk);

        // Six eofs with instant finishers -> two updates.
        pipe_hi = 0; pipe_lo = 0; bird_hi = 0; bird_lo = 0;
        repeat (2) begin
            push_exp(K_PIPE, 0);
            push_exp(K_BIRD, 0);
        end
        applyStimulus(6, 15);
        repeat (20) @(negedge clk);

        // Flap edge while waiting: flap high for the whole next bird window, low on the one after.
        @(negedge clk) flap_btn = 1'b1;
        repeat (2) @(negedge clk);
        flap_btn = 1'b0;
        push_exp(K_PIPE, 0);
        push_exp(K_BIRD, 3'b011);
        applyStimulus(FD, 4);
        repeat (20) @(negedge clk);
        push_exp(K_PIPE, 0);
        push_exp(K_BIRD, 3'b000);
        applyStimulus(FD, 4);
        repeat (20) @(negedge clk);

        // 100 pipe passes: BCD count with carry, saturating at 99.
        s = 8'h00;
        for (int i = 0; i < 100; i++) begin
            if (bcd_next(s) != s) push_exp(K_SCORE, bcd_next(s));
            s = bcd_next(s);
        end
        for (int i = 0; i < 100; i++) pulse_pass();
        repeat (4) @(negedge clk);

        // Collision during the pipe request.
        pipe_hi = 5; pipe_lo = 2; bird_hi = 5; bird_lo = 2;
        push_exp(K_PIPE, 0);
        push_exp(K_BIRD, 0);
`ifndef GAME_SEQ_GODMODE_EN
        push_exp(K_STATE, 2);
`endif
        applyStimulus(FD - 1, 4);
        @(negedge clk); x = 10'd639; y = 9'd479;
        @(negedge clk); x = 10'd0;   y = 9'd0;
        wait_pipe_req("collision_pipe");
        collide = 1'b1;
        @(negedge clk) collide = 1'b0;
        repeat (50) @(negedge clk);

        // Pipe passes and frames after the collision.
        for (int i = 0; i < 3; i++) pulse_pass();
`ifdef GAME_SEQ_GODMODE_EN
        push_exp(K_PIPE, 0);
        push_exp(K_BIRD, 0);
`endif
        applyStimulus(FD, 4);
        repeat (50) @(negedge clk);
`ifndef GAME_SEQ_GODMODE_EN
        push_exp(K_STATE, 1);
        push_exp(K_RPLAY, 1);
        push_exp(K_SCORE, 8'h00);
`endif
        press_start();

        // Asynchronous reset in the middle of a pipe request.
        push_exp(K_STATE, 0);
`ifdef GAME_SEQ_GODMODE_EN
        push_exp(K_SCORE, 8'h00);
`endif
        push_exp(K_PIPE, 0);
        applyStimulus(FD - 1, 4);
        @(negedge clk); x = 10'd639; y = 9'd479;
        @(negedge clk); x = 10'd0;   y = 9'd0;
        wait_pipe_req("reset_pipe");
        #2 resetGame_n = 1'b0;
        #1;
        n_checks++;
        if ({updatepipe, updatebird, flap, resetPlay} != 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL async_reset_drop actual=%b required=0000",
                     {updatepipe, updatebird, flap, resetPlay});
        end
        repeat (5) @(negedge clk);
        resetGame_n = 1'b1;
        repeat (10) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL pending_events actual=%0d required=0 next=%s",
                     exp_q.size(), kind_name(exp_q[0].kind));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
